// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter sharing the Hack RAM write port among four requesters.
// Optional grant locking is enabled with MEM_WRITE_ARBITER_LOCK_EN.
module mem_write_arbiter #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              req_valid,
    input  logic [4*ADDR_WIDTH-1:0] req_addr,
    input  logic [4*WIDTH-1:0]      req_data,
`ifdef MEM_WRITE_ARBITER_LOCK_EN
    input  logic [3:0]              req_lock,
`endif
    output logic [3:0]              req_ready,
    input  logic                    mem_busy,
    output logic                    mem_load,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]        mem_data,
    output logic [1:0]              grant_id
);

`ifdef MEM_WRITE_ARBITER_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
`else
    typedef enum logic {IDLE} state_t;
`endif

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] win;
    logic       found;
    logic       xfer;

`ifdef MEM_WRITE_ARBITER_LOCK_EN
    logic [1:0] owner, owner_n;
`endif

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int k = 3; k >= 0; k--) begin
            logic [1:0] idx;
            idx = ptr + 2'(k);
            if (req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`ifdef MEM_WRITE_ARBITER_LOCK_EN
        if (state == LOCKED) begin
            found = req_valid[owner];
            win   = owner;
        end
`endif
    end

    always_comb begin
        req_ready = 4'b0000;
        if (rst_n && found && !mem_busy)
            req_ready[win] = 1'b1;
    end

    assign xfer = |(req_valid & req_ready);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
`ifdef MEM_WRITE_ARBITER_LOCK_EN
        owner_n = owner;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    ptr_n = win + 2'd1;
                    if (req_lock[win]) begin
                        state_n = LOCKED;
                        owner_n = win;
                    end
                end
            end
            LOCKED: begin
                // Busy stalls the lock; release on owner drop or unlocked transfer.
                if (!mem_busy) begin
                    if (!req_valid[owner] || (xfer && !req_lock[owner])) begin
                        state_n = IDLE;
                        ptr_n   = owner + 2'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
`else
        if (state == IDLE && xfer)
            ptr_n = win + 2'd1;
        state_n = IDLE;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
`ifdef MEM_WRITE_ARBITER_LOCK_EN
            owner <= 2'd0;
`endif
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
`ifdef MEM_WRITE_ARBITER_LOCK_EN
            owner <= owner_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_load <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            grant_id <= 2'd0;
        end else begin
            mem_load <= xfer;
            if (xfer) begin
                mem_addr <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                mem_data <= req_data[win*WIDTH +: WIDTH];
                grant_id <= win;
            end
        end
    end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed self-checking bench for mem_write_arbiter.
// Lock scenario is exercised when MEM_WRITE_ARBITER_LOCK_EN is defined.
module tb_mem_write_arbiter;

    localparam int WIDTH      = 16;
    localparam int ADDR_WIDTH = 15;

    logic                    clk;
    logic                    rst_n;
    logic [3:0]              req_valid;
    logic [4*ADDR_WIDTH-1:0] req_addr;
    logic [4*WIDTH-1:0]      req_data;
    logic [3:0]              req_lock;
    logic [3:0]              req_ready;
    logic                    mem_busy;
    logic                    mem_load;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [WIDTH-1:0]        mem_data;
    logic [1:0]              grant_id;

    int n_checks = 0;
    int n_errors = 0;

    mem_write_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
`ifdef MEM_WRITE_ARBITER_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .mem_busy  (mem_busy),
        .mem_load  (mem_load),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [14:0] a,
                           input logic [15:0] d);
        req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
        req_data[i*WIDTH +: WIDTH]           = d;
    endtask

    task automatic expect_write(input string tag, input logic [1:0] g,
                                input logic [14:0] a, input logic [15:0] d);
        check({tag, "_load"}, 32'(mem_load), 32'd1);
        check({tag, "_gid"}, 32'(grant_id), 32'(g));
        check({tag, "_addr"}, 32'(mem_addr), 32'(a));
        check({tag, "_data"}, 32'(mem_data), 32'(d));
    endtask

    initial begin
        logic [1:0] exp_g;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_lock  = 4'b0000;
        mem_busy  = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < 4; i++)
            set_req(i, 15'(16 + i), 16'(16'h0100 + i));

        // Reset with all requesters valid
        step();
        check("rst_ready", 32'(req_ready), 32'h0);
        step();
        check("rst_load", 32'(mem_load), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_ready2", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        #1;
        check("first_ready", 32'(req_ready), 32'b0001);

        // Round robin, 8 consecutive writes
        for (int n = 0; n < 8; n++) begin
            exp_g = 2'(n);
            step();
            expect_write("rr", exp_g, 15'(16 + n % 4), 16'(16'h0100 + n % 4));
        end

        // Single requester 2, ptr moves to 3
        req_valid = 4'b0100;
        set_req(2, 15'h4000, 16'hBEEF);
        #1;
        check("r2_ready", 32'(req_ready), 32'b0100);
        step();
        expect_write("r2", 2'd2, 15'h4000, 16'hBEEF);
        req_valid = 4'b1111;
        #1;
        check("ptr3_ready", 32'(req_ready), 32'b1000);
        req_valid = 4'b0000;
        #1;
        check("drop_ready", 32'(req_ready), 32'h0);
        step();
        check("idle_load", 32'(mem_load), 32'd0);
        check("hold_addr", 32'(mem_addr), 32'h4000);
        check("hold_gid", 32'(grant_id), 32'd2);

        // Grant 3 wraps ptr to 0
        req_valid = 4'b1000;
        step();
        expect_write("wrap", 2'd3, 15'd19, 16'h0103);

        // Back-pressure for 3 cycles with 1 and 3 valid
        set_req(1, 15'h21, 16'hA001);
        set_req(3, 15'h23, 16'hA003);
        req_valid = 4'b1010;
        mem_busy  = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            check("busy_ready", 32'(req_ready), 32'h0);
            step();
            check("busy_load", 32'(mem_load), 32'd0);
        end
        mem_busy = 1'b0;
        #1;
        check("unbusy_ready", 32'(req_ready), 32'b0010);
        step();
        expect_write("busy_g1", 2'd1, 15'h21, 16'hA001);
        step();
        expect_write("busy_g3", 2'd3, 15'h23, 16'hA003);

        // Reset mid-stream after two accepted writes
        set_req(1, 15'd17, 16'h0101);
        set_req(3, 15'd19, 16'h0103);
        req_valid = 4'b1111;
        step();
        expect_write("mid_g0", 2'd0, 15'd16, 16'h0100);
        step();
        expect_write("mid_g1", 2'd1, 15'd17, 16'h0101);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        step();
        check("mid_load", 32'(mem_load), 32'd0);
        check("mid_addr", 32'(mem_addr), 32'd0);
        check("mid_data", 32'(mem_data), 32'd0);
        check("mid_gid", 32'(grant_id), 32'd0);
        rst_n = 1'b1;
        #1;
        check("restart_ready", 32'(req_ready), 32'b0001);
        step();
        expect_write("restart", 2'd0, 15'd16, 16'h0100);

`ifdef MEM_WRITE_ARBITER_LOCK_EN
        // Requester 1 holds the lock for three transfers
        req_lock = 4'b0010;
        step();
        expect_write("lk1", 2'd1, 15'd17, 16'h0101);
        step();
        expect_write("lk2", 2'd1, 15'd17, 16'h0101);
        req_lock = 4'b0000;
        step();
        expect_write("lk3", 2'd1, 15'd17, 16'h0101);
        step();
        expect_write("post2", 2'd2, 15'd18, 16'h0102);
        step();
        expect_write("post3", 2'd3, 15'd19, 16'h0103);
        step();
        expect_write("post0", 2'd0, 15'd16, 16'h0100);
`endif

        req_valid = 4'b0000;
        step();
        check("end_load", 32'(mem_load), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
